// File: rtl/bnn_layer_scheduler.sv
// Sequencer that time-multiplexes one binary neuron unit across the M neurons of a BNN layer.
// Optional argmax tracking of the neuron popcounts is enabled with `define BNN_SCHED_ARGMAX_EN.
module bnn_layer_scheduler #(
  parameter int N  = 16,
  parameter int M  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_act,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_result,
  output logic          busy,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_wt_data,
  input  logic [7:0]    mem_thr_data,
  output logic [N-1:0]  nu_inputs,
  output logic [N-1:0]  nu_weights,
  output logic [7:0]    nu_threshold,
  output logic          nu_valid_in,
  input  logic          nu_out,
  input  logic          nu_valid_out,
  input  logic [7:0]    nu_popcount,
  output logic          protocol_err,
  output logic [AW-1:0] out_argmax
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [AW:0] M_CNT = (AW+1)'(M);

  state_t        state_q, state_d;
  logic [N-1:0]  act_q;
  logic [AW:0]   issue_cnt_q, issue_cnt_d;
  logic [AW:0]   cap_cnt_q, cap_cnt_d;
  logic [M-1:0]  result_q, result_d;
  logic          nu_valid_q;
  logic          err_q, err_d;
  logic          flush_q;
  logic          act_load;
  logic          capture;
  logic          unexpected;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    result_d    = result_q;
    err_d       = err_q;
    act_load    = 1'b0;

    capture    = nu_valid_out && (state_q == ISSUE || state_q == DRAIN) && (cap_cnt_q < M_CNT);
    // flush_q masks a neuron result still in flight from before the last reset.
    unexpected = nu_valid_out && !flush_q &&
                 (state_q == IDLE || state_q == DONE || (state_q == DRAIN && cap_cnt_q >= M_CNT));

    if (unexpected) err_d = 1'b1;

    if (capture) begin
      result_d[cap_cnt_q[AW-1:0]] = nu_out;
      cap_cnt_d                   = cap_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          act_load    = 1'b1;
          result_d    = '0;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == M_CNT - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        if (cap_cnt_d == M_CNT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      result_q    <= '0;
      nu_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      flush_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      result_q    <= result_d;
      nu_valid_q  <= mem_rd_en;
      err_q       <= err_d;
      flush_q     <= 1'b0;
      if (act_load) act_q <= in_act;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign mem_rd_en    = (state_q == ISSUE);
  assign mem_addr     = (state_q == ISSUE) ? issue_cnt_q[AW-1:0] : '0;
  assign out_result   = result_q;
  assign protocol_err = err_q;

  // Weight and threshold rows arrive straight from memory; the activation is held for the layer.
  assign nu_inputs    = act_q;
  assign nu_weights   = mem_wt_data;
  assign nu_threshold = mem_thr_data;
  assign nu_valid_in  = nu_valid_q;

`ifdef BNN_SCHED_ARGMAX_EN
  logic [7:0]    max_pop_q;
  logic [AW-1:0] argmax_q;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_pop_q <= '0;
      argmax_q  <= '0;
    end else if (act_load) begin
      max_pop_q <= '0;
      argmax_q  <= '0;
    end else if (capture && (nu_popcount > max_pop_q)) begin
      max_pop_q <= nu_popcount;
      argmax_q  <= cap_cnt_q[AW-1:0];
    end
  end

  assign out_argmax = argmax_q;
`else
  logic unused_popcount;
  assign unused_popcount = ^nu_popcount;
  assign out_argmax      = '0;
`endif

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Scoreboard bench for bnn_layer_scheduler with behavioural parameter memory and neuron unit.
// Expected layer results come from a plain-arithmetic reference over the memory arrays.
module tb_bnn_layer_scheduler;
  localparam int N  = 16;
  localparam int M  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_act = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [M-1:0]  out_result;
  logic          busy;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wt_data = '0;
  logic [7:0]    mem_thr_data = '0;
  logic [N-1:0]  nu_inputs;
  logic [N-1:0]  nu_weights;
  logic [7:0]    nu_threshold;
  logic          nu_valid_in;
  logic          nu_out = 1'b0;
  logic          nu_vo_q = 1'b0;
  logic          inj = 1'b0;
  logic          nu_valid_out;
  logic [7:0]    nu_popcount = '0;
  logic          protocol_err;
  logic [AW-1:0] out_argmax;

  logic [N-1:0] wt_mem  [M];
  logic [7:0]   thr_mem [M];

  typedef struct packed {
    logic [M-1:0]  res;
    logic [AW-1:0] amax;
    int            acc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_handoff = -100;
  int first_ov = 0;
  bit ov_prev = 1'b0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  bnn_layer_scheduler #(.N(N), .M(M), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wt_data(mem_wt_data), .mem_thr_data(mem_thr_data),
    .nu_inputs(nu_inputs), .nu_weights(nu_weights), .nu_threshold(nu_threshold),
    .nu_valid_in(nu_valid_in), .nu_out(nu_out), .nu_valid_out(nu_valid_out),
    .nu_popcount(nu_popcount), .protocol_err(protocol_err), .out_argmax(out_argmax)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous parameter memory, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_wt_data  <= wt_mem[mem_addr];
      mem_thr_data <= thr_mem[mem_addr];
    end
  end

  // Neuron unit stand-in: registered XNOR/popcount/threshold, not reset.
  always @(posedge clk) begin
    int pc;
    pc = $countones(~(nu_inputs ^ nu_weights));
    nu_vo_q     <= nu_valid_in;
    nu_out      <= (pc >= int'(nu_threshold));
    nu_popcount <= 8'(pc);
  end

  assign nu_valid_out = nu_vo_q | inj;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_layer(input logic [N-1:0] act, input int acc);
    exp_t e;
    int   best;
    int   idx;
    int   pc;
    best  = -1;
    idx   = 0;
    e.res = '0;
    for (int k = 0; k < M; k++) begin
      pc = $countones(~(act ^ wt_mem[k]));
      e.res[k] = (pc >= int'(thr_mem[k]));
      if (pc > best) begin
        best = pc;
        idx  = k;
      end
    end
`ifdef BNN_SCHED_ARGMAX_EN
    e.amax = AW'(idx);
`else
    e.amax = '0;
`endif
    e.acc = acc;
    return e;
  endfunction

  // Monitor: pops the scoreboard at each handoff.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) first_ov = cyc;
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_out_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_result", 32'(out_result), 32'(e.res));
            check("out_argmax", 32'(out_argmax), 32'(e.amax));
            check("latency", 32'(first_ov - e.acc), 32'(M + 3));
          end
          last_handoff = cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [N-1:0] act, output int acc);
    int w;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_act   = act;
    acc      = -1;
    w        = 0;
    while (acc < 0 && w < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        sb.push_back(ref_layer(act, acc));
      end
      w++;
    end
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_act   = N'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"},     32'(in_ready),     32'd1);
    check({tag, "_out_valid"},    32'(out_valid),    32'd0);
    check({tag, "_out_result"},   32'(out_result),   32'd0);
    check({tag, "_busy"},         32'(busy),         32'd0);
    check({tag, "_mem_rd_en"},    32'(mem_rd_en),    32'd0);
    check({tag, "_mem_addr"},     32'(mem_addr),     32'd0);
    check({tag, "_nu_valid_in"},  32'(nu_valid_in),  32'd0);
    check({tag, "_protocol_err"}, 32'(protocol_err), 32'd0);
    check({tag, "_out_argmax"},   32'(out_argmax),   32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_ramp(input logic [7:0] thr);
    for (int k = 0; k < M; k++) begin
      logic [31:0] w32;
      w32        = (32'd1 << (2 * k)) - 32'd1;
      wt_mem[k]  = w32[N-1:0];
      thr_mem[k] = thr;
    end
  endtask

  initial begin
    int acc;
    int acc2;
    logic [N-1:0] act;
    for (int k = 0; k < M; k++) begin
      wt_mem[k]  = '0;
      thr_mem[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");

    // Ramp weights, thresholds 8, 0, 17.
    out_ready = 1'b1;
    load_ramp(8'd8);
    send(16'hFFFF, acc);
    wait_idle();
    load_ramp(8'd0);
    send(16'hFFFF, acc);
    wait_idle();
    load_ramp(8'd17);
    send(16'hFFFF, acc);
    wait_idle();

    // Back-to-back with out_ready high: second accept the cycle after the first handoff.
    load_ramp(8'd8);
    send(16'hFFFF, acc);
    send(16'h0F0F, acc2);
    check("b2b_accept", 32'(acc2), 32'(last_handoff + 1));
    wait_idle();

    // Stall in DONE with an in_valid pulse that must be ignored.
    out_ready = 1'b0;
    send(N'($urandom), acc);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("stall_reach_done", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i == 2);
      in_act   = N'($urandom);
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      if (sb.size() != 0) check("stall_result", 32'(out_result), 32'(sb[0].res));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("pulse_not_accepted", 32'(busy), 32'd0);

    // Reset at cycle 5 of a layer, then an all-zero layer.
    send(16'hA5A5, acc);
    while (cyc < acc + 5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midreset");
    for (int k = 0; k < M; k++) begin
      wt_mem[k]  = '0;
      thr_mem[k] = 8'd16;
    end
    send(16'h0000, acc);
    wait_idle();
    check("midreset_no_err", 32'(protocol_err), 32'd0);

    // Unexpected nu_valid_out in IDLE: sticky until reset.
    @(posedge clk);
    #1;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    @(negedge clk);
    check("err_set", 32'(protocol_err), 32'd1);
    load_ramp(8'd8);
    send(16'hFFFF, acc);
    wait_idle();
    check("err_sticky", 32'(protocol_err), 32'd1);
    pulse_reset();
    check("err_cleared", 32'(protocol_err), 32'd0);

    // All rows equal to the activation: every popcount 16, tie keeps index 0.
    act = N'($urandom);
    for (int k = 0; k < M; k++) begin
      wt_mem[k]  = act;
      thr_mem[k] = 8'($urandom_range(0, 17));
    end
    send(act, acc);
    wait_idle();

    // Randomized layers with random downstream backpressure.
    rand_ready = 1'b1;
    for (int l = 0; l < 24; l++) begin
      for (int k = 0; k < M; k++) begin
        wt_mem[k]  = N'($urandom);
        thr_mem[k] = 8'($urandom_range(4, 13));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(N'($urandom), acc);
      wait_idle();
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("final_no_err", 32'(protocol_err), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bnn_layer_scheduler.md
Name: bnn_layer_scheduler

Overview:
Sequencer that time-multiplexes one binary neuron unit (XNOR/popcount/threshold, 1-cycle registered output) across the M neurons of a fully-connected BNN layer. It accepts one N-bit activation vector and streams weight and threshold rows from a synchronous 1-cycle-latency parameter memory into the neuron unit at one neuron per cycle. It collects the M output bits into a result vector presented on a valid/ready port. It sits between the layer input buffer and the next layer or output stage.

Parameters:
N, 16, activation/weight vector width (must match neuron unit)
M, 8, neurons per layer; M >= 2
AW, $clog2(M), parameter memory address width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  activation vector valid
in_ready  output  1  scheduler can accept a vector
in_act  input  N  binary activation vector
out_valid  output  1  layer result valid
out_ready  input  1  downstream accepts result
out_result  output  M  bit k = neuron k output
busy  output  1  high whenever state != IDLE
mem_rd_en  output  1  parameter memory read strobe
mem_addr  output  AW  neuron index being read
mem_wt_data  input  N  weight row, valid 1 cycle after mem_rd_en
mem_thr_data  input  8  threshold, valid 1 cycle after mem_rd_en
nu_inputs  output  N  to neuron unit inputs
nu_weights  output  N  to neuron unit weights
nu_threshold  output  8  to neuron unit threshold
nu_valid_in  output  1  to neuron unit valid_in
nu_out  input  1  from neuron unit out
nu_valid_out  input  1  from neuron unit valid_out
nu_popcount  input  8  from neuron unit debug_popcount
protocol_err  output  1  sticky: unexpected nu_valid_out
out_argmax  output  AW  see Optional Feature

Behaviour:
- Reset (synchronous, rst high at clk edge): state IDLE; in_ready=1; out_valid=0; out_result=0; busy=0; mem_rd_en=0; mem_addr=0; nu_valid_in=0; protocol_err=0; out_argmax=0; all counters 0. Reset mid-layer discards partial results; in-flight nu_valid_out arriving after reset is ignored and does not set protocol_err.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid, latch in_act into an activation register, clear out_result, issue_cnt=0, cap_cnt=0, go to ISSUE.
- ISSUE: mem_rd_en=1, mem_addr=issue_cnt, issue_cnt++. After issuing address M-1, go to DRAIN.
- Read pipeline: nu_valid_in = mem_rd_en delayed 1 cycle (registered). nu_weights=mem_wt_data and nu_threshold=mem_thr_data pass through combinationally. nu_inputs = latched activation, constant for the whole layer.
- Capture, in ISSUE or DRAIN: on nu_valid_out, out_result[cap_cnt] <= nu_out and cap_cnt++. When cap_cnt reaches M, go to DONE.
- DONE: out_valid=1, out_result stable until out_ready. On out_ready: out_valid=0, go to IDLE. in_ready stays 0 in DONE, so the next vector is accepted no earlier than the cycle after handoff.
- Timing: accept at cycle 0; reads at cycles 1..M; nu_valid_in at cycles 2..M+1; nu_valid_out at cycles 3..M+2; out_valid high from cycle M+3 (11 for M=8). Throughput is one neuron per cycle.
- in_valid outside IDLE is ignored; in_act is not sampled.
- protocol_err is set, and held until rst, if nu_valid_out is seen in IDLE or DONE, or in DRAIN after cap_cnt==M.
- No arithmetic on popcount except the optional compare; all counters are AW+1 bits wide, with no wrap within a layer.

Optional Feature:
Macro BNN_SCHED_ARGMAX_EN.
- Defined: track the maximum nu_popcount over the layer (8-bit unsigned compare). Replace the stored index only on a strictly greater value, so ties keep the lowest index. out_argmax is registered, cleared at layer start, and valid when out_valid=1.
- Undefined: no tracking logic; out_argmax tied to 0.

Test Plan:
1. N=16, M=8, in_act=16'hFFFF, weight row k = (1<<2k)-1 (popcount 2k), all thresholds 8 -> out_result=8'hF0, out_valid exactly 11 cycles after accept; with ARGMAX_EN, out_argmax=7.
2. Same weights, thresholds 0 -> out_result=8'hFF. Then thresholds 17 -> out_result=8'h00. Two layers back-to-back with out_ready held high -> second accept the cycle after the first handoff.
3. out_ready held low for 5 cycles in DONE, in_valid pulsed meanwhile -> out_result stable, in_ready=0, the pulsed vector is not accepted, busy=1.
4. rst asserted at cycle 5 of a layer -> next cycle all outputs at reset values. New layer with in_act=16'h0000, weights=0, thresholds 16 -> out_result=8'hFF, protocol_err=0.
5. Inject nu_valid_out in IDLE -> protocol_err=1 and stays 1 through later layers until rst.
6. ARGMAX_EN with every weight row = in_act (all popcount 16) -> out_argmax=0 (tie rule).
